asoc_event_framer: RTL and testbench
====================================

// Module: asoc_event_framer
// PURPOSE
//  Packs per-event ASOC sample bursts into a 32-bit DAQ word stream with valid/ready flow control.
//  It sits between the ASOC capture stage, which delivers 12-bit samples per trigger, and the host/DAQ link.
//  Each event is emitted as one frame: header word, timestamp word, packed payload words, trailer word.
// PARAMETERS
//  SAMPLE_W    12   sample width; fixed by the ASOC format, and packing assumes 12
//  CH_W        4    channel index width
//  NS_W        9    width of evt_nsamples (0..511)
//  MAX_SAMPLES 256  per-event sample cap; larger requests are clamped
//  FIFO_DEPTH  16   output word FIFO depth; must be a power of 2, minimum 4
// PORTS
//  clk_sys       in   1          system clock
//  rst_sys_n     in   1          asynchronous reset, active-low
//  evt_start     in   1          1-cycle pulse; begins a frame
//  evt_channel   in   CH_W       channel, sampled with evt_start
//  evt_nsamples  in   NS_W       samples to expect, sampled with evt_start
//  smp_valid     in   1          sample handshake from the capture stage
//  smp_data      in   SAMPLE_W   sample value
//  smp_ready     out  1          framer can accept a sample
//  daq_data      out  32         frame word
//  daq_valid     out  1          daq_data is valid
//  daq_ready     in   1          consumer accepts the word
//  busy          out  1          frame in progress (state != IDLE)
//  evt_dropped   out  1          1-cycle pulse when evt_start is ignored
//  drop_cnt      out  16         count of dropped starts; saturates at 0xFFFF
// BEHAVIOUR
//  Reset (async, any time): every output goes to 0, the FIFO is emptied, seq=0, ts=0, FSM=IDLE.
//    A partial frame is discarded; nothing partial is resumed.
//  ts: 32-bit free-running counter, +1 every clk_sys; wraps from 0xFFFFFFFF to 0.
//  seq: 16-bit event number; increments after each accepted event and wraps.
//  FSM states: IDLE, HDR, TS, PAY, TRL.
//    - IDLE: on evt_start, latch channel, N = min(nsamples, MAX_SAMPLES), clamp flag, and ts; go to HDR.
//    - HDR: push {8'hA5, ch, 4'h0, seq} when the FIFO is not full; go to TS.
//    - TS: push the latched ts when the FIFO is not full; go to PAY (or TRL if N==0).
//    - PAY: accept samples until N have been taken, then flush any pending half-word; go to TRL.
//    - TRL: push {8'h5A, clamp, 14'h0, N[8:0]}; seq++; go to IDLE.
//  Any state waits while the FIFO is full. There is no push when full, so no word is ever lost.
//  Packing: even-indexed sample k goes to bits [27:16], odd sample k+1 to bits [11:0]; all other bits are 0.
//    - The first sample of a pair is held in pack_reg; the word is pushed when the second sample arrives.
//    - If N is odd, the final word is pushed with [11:0]=0 on the cycle after the last sample.
//  smp_ready = (state==PAY) && (remaining>0) && (!pair_pending || !fifo_full).
//    It is 0 in every other state; samples offered outside PAY are not consumed.
//  evt_start seen while busy, or in the same cycle TRL returns to IDLE: ignore it.
//    evt_dropped pulses for 1 cycle and drop_cnt increments (saturating). The current frame is unaffected.
//  Output FIFO is synchronous, show-ahead; a word pops on daq_valid && daq_ready.
//    - daq_valid = !fifo_empty.
//    - daq_data holds stable while daq_valid && !daq_ready.
//    - Simultaneous push and pop when full is not allowed: push is gated on !full.
//  Latency, with an empty FIFO and daq_ready=1:
//    - header appears on daq_data 2 clk_sys after the evt_start cycle;
//    - consecutive words follow on consecutive cycles when the source is not stalled.
// STRUCTURE
//  Shared package asoc_pkg holds:
//    - constants HDR_MAGIC=8'hA5 and TRL_MAGIC=8'h5A, and word-field bit positions;
//    - typedef framer_state_t for the FSM states.
//  Sub-module asoc_word_fifo: generic synchronous FIFO (WIDTH=32, DEPTH=FIFO_DEPTH) with full/empty flags.
//  Top level holds: the FSM, ts and seq counters, pack_reg, remaining counter, and the drop counter.
// TESTING
//  1. Assert reset mid-PAY with rst_sys_n=0 for 3 cycles -> daq_valid/busy/smp_ready drop immediately;
//     the next event has header seq=0x0000.
//  2. ch=3, N=4, samples 0x001..0x004, daq_ready=1 ->
//     words A5300000, ts, 00010002, 00030004, 5A000004; header appears 2 cycles after evt_start.
//  3. ch=1, N=3, samples 0xABC,0x123,0xFFF -> payload 0ABC0123 then 0FFF0000; trailer 5A000003.
//  4. N=64 with daq_ready=0 for 40 cycles -> FIFO holds 16 words and smp_ready falls;
//     daq_data is stable while stalled; after release, all 32 payload words arrive in order with no loss or duplication.
//  5. evt_start during PAY -> evt_dropped pulses once, drop_cnt=1, current frame intact, next accepted event seq=1.
//  6. N=0 gives exactly 3 words ending in 5A000000. N=300 gives 256 samples and trailer 5A800100.

Source files
------------

// File: rtl/asoc_pkg.sv
// Shared constants, word-layout helpers and FSM state type for the ASOC event framer.
package asoc_pkg;

  localparam logic [7:0] HDR_MAGIC     = 8'hA5;
  localparam logic [7:0] TRL_MAGIC     = 8'h5A;
  localparam int         MAGIC_LSB     = 24;
  localparam int         HDR_CH_LSB    = 20;
  localparam int         TRL_CLAMP_BIT = 23;
  localparam int         PAY_HI_LSB    = 16;
  localparam int         PAY_LO_LSB    = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_TS,
    ST_PAY,
    ST_TRL
  } framer_state_t;

  function automatic logic [31:0] hdr_word(input logic [3:0] ch, input logic [15:0] seq);
    logic [31:0] w;
    w = '0;
    w[MAGIC_LSB +: 8]  = HDR_MAGIC;
    w[HDR_CH_LSB +: 4] = ch;
    w[15:0]            = seq;
    return w;
  endfunction

  function automatic logic [31:0] trl_word(input logic clamp, input logic [8:0] n);
    logic [31:0] w;
    w = '0;
    w[MAGIC_LSB +: 8]   = TRL_MAGIC;
    w[TRL_CLAMP_BIT]    = clamp;
    w[8:0]              = n;
    return w;
  endfunction

  // Even sample in the upper 12-bit field, odd sample in the lower one.
  function automatic logic [31:0] pay_word(input logic [11:0] hi, input logic [11:0] lo);
    logic [31:0] w;
    w = '0;
    w[PAY_HI_LSB +: 12] = hi;
    w[PAY_LO_LSB +: 12] = lo;
    return w;
  endfunction

endpackage

// File: rtl/asoc_word_fifo.sv
// Generic synchronous show-ahead FIFO; pushes are dropped by the caller's gating, never here silently.
module asoc_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  // Forced to zero when empty so the output port is clean out of reset.
  assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/asoc_event_framer.sv
// Frames each ASOC trigger burst as header, timestamp, packed 12-bit sample pairs and trailer
// into a 32-bit valid/ready word stream.
module asoc_event_framer
  import asoc_pkg::*;
#(
  parameter int SAMPLE_W    = 12,
  parameter int CH_W        = 4,
  parameter int NS_W        = 9,
  parameter int MAX_SAMPLES = 256,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                clk_sys,
  input  logic                rst_sys_n,
  input  logic                evt_start,
  input  logic [CH_W-1:0]     evt_channel,
  input  logic [NS_W-1:0]     evt_nsamples,
  input  logic                smp_valid,
  input  logic [SAMPLE_W-1:0] smp_data,
  output logic                smp_ready,
  output logic [31:0]         daq_data,
  output logic                daq_valid,
  input  logic                daq_ready,
  output logic                busy,
  output logic                evt_dropped,
  output logic [15:0]         drop_cnt
);

  localparam logic [NS_W-1:0] MAX_N = NS_W'(MAX_SAMPLES);

  framer_state_t       state_q, state_d;
  logic [31:0]         ts_q, ts_d, ts_lat_q, ts_lat_d;
  logic [15:0]         seq_q, seq_d, drop_cnt_q, drop_cnt_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NS_W-1:0]     n_q, n_d, remaining_q, remaining_d;
  logic                clamp_q, clamp_d;
  logic                pair_pending_q, pair_pending_d;
  logic                evt_dropped_q, evt_dropped_d;
  logic [SAMPLE_W-1:0] pack_q, pack_d;
  logic                fifo_push, fifo_full, fifo_empty;
  logic [31:0]         push_word;
  logic                smp_take, start_drop, req_clamp;

  // A second sample may only be taken when its completed word has room to go.
  assign smp_ready   = (state_q == ST_PAY) && (remaining_q != '0) &&
                       (!pair_pending_q || !fifo_full);
  assign smp_take    = smp_valid && smp_ready;
  assign start_drop  = evt_start && (state_q != ST_IDLE);
  assign req_clamp   = (evt_nsamples > MAX_N);
  assign busy        = (state_q != ST_IDLE);
  assign daq_valid   = !fifo_empty;
  assign evt_dropped = evt_dropped_q;
  assign drop_cnt    = drop_cnt_q;

  always_comb begin
    state_d        = state_q;
    ts_d           = ts_q + 32'd1;
    ts_lat_d       = ts_lat_q;
    seq_d          = seq_q;
    ch_d           = ch_q;
    n_d            = n_q;
    remaining_d    = remaining_q;
    clamp_d        = clamp_q;
    pair_pending_d = pair_pending_q;
    pack_d         = pack_q;
    evt_dropped_d  = start_drop;
    drop_cnt_d     = drop_cnt_q;
    fifo_push      = 1'b0;
    push_word      = '0;

    if (start_drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;

    case (state_q)
      ST_IDLE: begin
        if (evt_start) begin
          ch_d           = evt_channel;
          clamp_d        = req_clamp;
          n_d            = req_clamp ? MAX_N : evt_nsamples;
          remaining_d    = req_clamp ? MAX_N : evt_nsamples;
          pair_pending_d = 1'b0;
          ts_lat_d       = ts_q;
          state_d        = ST_HDR;
        end
      end
      ST_HDR: begin
        if (!fifo_full) begin
          fifo_push = 1'b1;
          push_word = hdr_word(ch_q, seq_q);
          state_d   = ST_TS;
        end
      end
      ST_TS: begin
        if (!fifo_full) begin
          fifo_push = 1'b1;
          push_word = ts_lat_q;
          state_d   = (n_q == '0) ? ST_TRL : ST_PAY;
        end
      end
      ST_PAY: begin
        if (smp_take) begin
          remaining_d = remaining_q - 1'b1;
          if (pair_pending_q) begin
            fifo_push      = 1'b1;
            push_word      = pay_word(pack_q, smp_data);
            pair_pending_d = 1'b0;
            if (remaining_q == NS_W'(1)) state_d = ST_TRL;
          end else begin
            pack_d         = smp_data;
            pair_pending_d = 1'b1;
          end
        end else if (remaining_q == '0) begin
          // Odd count: the lone final sample goes out with an empty low field.
          if (!pair_pending_q) begin
            state_d = ST_TRL;
          end else if (!fifo_full) begin
            fifo_push      = 1'b1;
            push_word      = pay_word(pack_q, 12'h000);
            pair_pending_d = 1'b0;
            state_d        = ST_TRL;
          end
        end
      end
      ST_TRL: begin
        if (!fifo_full) begin
          fifo_push = 1'b1;
          push_word = trl_word(clamp_q, n_q);
          seq_d     = seq_q + 16'd1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_sys_n) begin
    if (!rst_sys_n) begin
      state_q        <= ST_IDLE;
      ts_q           <= '0;
      ts_lat_q       <= '0;
      seq_q          <= '0;
      ch_q           <= '0;
      n_q            <= '0;
      remaining_q    <= '0;
      clamp_q        <= 1'b0;
      pair_pending_q <= 1'b0;
      pack_q         <= '0;
      evt_dropped_q  <= 1'b0;
      drop_cnt_q     <= '0;
    end else begin
      state_q        <= state_d;
      ts_q           <= ts_d;
      ts_lat_q       <= ts_lat_d;
      seq_q          <= seq_d;
      ch_q           <= ch_d;
      n_q            <= n_d;
      remaining_q    <= remaining_d;
      clamp_q        <= clamp_d;
      pair_pending_q <= pair_pending_d;
      pack_q         <= pack_d;
      evt_dropped_q  <= evt_dropped_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  asoc_word_fifo #(
    .WIDTH (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk_sys),
    .rst_n     (rst_sys_n),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (daq_ready),
    .pop_data  (daq_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

endmodule

// File: tb/tb_asoc_event_framer.sv
// Bench for asoc_event_framer: directed vector table, hand-built stall/drop/reset sequences and
// randomized frames compared against a frame-level reference model.
module tb_asoc_event_framer;

  logic        clk_sys = 1'b0;
  logic        rst_sys_n = 1'b0;
  logic        evt_start = 1'b0;
  logic [3:0]  evt_channel = '0;
  logic [8:0]  evt_nsamples = '0;
  logic        smp_valid = 1'b0;
  logic [11:0] smp_data = '0;
  logic        smp_ready;
  logic [31:0] daq_data;
  logic        daq_valid;
  logic        daq_ready = 1'b1;
  logic        busy;
  logic        evt_dropped;
  logic [15:0] drop_cnt;

  asoc_event_framer dut (
    .clk_sys      (clk_sys),
    .rst_sys_n    (rst_sys_n),
    .evt_start    (evt_start),
    .evt_channel  (evt_channel),
    .evt_nsamples (evt_nsamples),
    .smp_valid    (smp_valid),
    .smp_data     (smp_data),
    .smp_ready    (smp_ready),
    .daq_data     (daq_data),
    .daq_valid    (daq_valid),
    .daq_ready    (daq_ready),
    .busy         (busy),
    .evt_dropped  (evt_dropped),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [3:0]       ch;
    logic [8:0]       ns;
    logic [3:0][11:0] smp;
    int               words;
    logic [31:0]      hdr;
    logic [31:0]      pay_first;
    logic [31:0]      pay_last;
    logic [31:0]      trl;
  } vec_t;

  vec_t        vecs[5];
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          exp_seq = 0;
  int          exp_drops = 0;
  int          drop_pulses = 0;
  int          start_cyc = 0;
  int          first_cyc = 0;
  bit          rand_ready = 1'b0;
  bit          gap_mode = 1'b0;
  logic [31:0] exp_ts;
  logic [11:0] smp_q[$];
  logic [11:0] frame_smp[$];
  logic [31:0] got_q[$];
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%08h expected=%08h", name, got, exp);
    end
  endtask

  // One clock: observe handshakes at the falling edge, update stimulus just after the rising edge.
  task automatic tick();
    bit took;
    @(negedge clk_sys);
    if (daq_valid && daq_ready) begin
      if (got_q.size() == 0) first_cyc = cyc;
      got_q.push_back(daq_data);
    end
    if (evt_dropped) drop_pulses++;
    took = smp_valid && smp_ready;
    @(posedge clk_sys);
    #1;
    cyc++;
    evt_start = 1'b0;
    if (took && smp_q.size() > 0) void'(smp_q.pop_front());
    if (rand_ready) daq_ready = ($urandom_range(0, 3) != 0);
    smp_valid = (smp_q.size() > 0) && (!gap_mode || $urandom_range(0, 3) != 0);
    smp_data  = (smp_q.size() > 0) ? smp_q[0] : 12'($urandom);
  endtask

  task automatic release_reset();
    rst_sys_n = 1'b1;
    cyc = 0;
    exp_seq = 0;
    exp_drops = 0;
    drop_pulses = 0;
    smp_q.delete();
    got_q.delete();
    smp_valid = 1'b0;
  endtask

  // Builds the expected frame from the event parameters, then issues evt_start for one cycle.
  task automatic start_frame(input logic [3:0] ch, input logic [8:0] ns);
    int          neff;
    logic [31:0] w;
    neff = (ns > 9'd256) ? 256 : int'(ns);
    exp_q.delete();
    got_q.delete();
    exp_ts = 32'(cyc);
    exp_q.push_back(32'hA500_0000 | (32'(ch) << 20) | 32'(exp_seq & 'hFFFF));
    exp_q.push_back(exp_ts);
    for (int i = 0; i < neff; i += 2) begin
      w = 32'(frame_smp[i]) << 16;
      if (i + 1 < neff) w = w | 32'(frame_smp[i+1]);
      exp_q.push_back(w);
    end
    exp_q.push_back(32'h5A00_0000 | ((ns > 9'd256) ? 32'h0080_0000 : 32'h0) | 32'(neff));
    exp_seq++;
    foreach (frame_smp[i]) smp_q.push_back(frame_smp[i]);
    if (smp_q.size() > 0) begin
      smp_valid = 1'b1;
      smp_data  = smp_q[0];
    end
    evt_channel  = ch;
    evt_nsamples = ns;
    evt_start    = 1'b1;
    start_cyc    = cyc;
    tick();
  endtask

  task automatic finish_frame(input string name);
    int budget;
    int bad;
    budget = 0;
    bad = -1;
    while (got_q.size() < exp_q.size() && budget < 4000) begin
      tick();
      budget++;
    end
    repeat (2) tick();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL %s_words: got=%0d expected=%0d", name, got_q.size(), exp_q.size());
    end
    checks++;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i] && bad < 0) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s_frame: word %0d got=%08h expected=%08h", name, bad, got_q[bad], exp_q[bad]);
    end
    chk({name, "_idle"}, 32'(busy), 32'h0);
    smp_q.delete();
    smp_valid = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] hold;
    bit          seen;
    int          unstable;
    logic [8:0]  ns;
    int          neff;

    vecs[0] = '{ch:4'h3, ns:9'd4,   smp:{12'h004, 12'h003, 12'h002, 12'h001}, words:5,
                hdr:32'hA530_0000, pay_first:32'h0001_0002, pay_last:32'h0003_0004, trl:32'h5A00_0004};
    vecs[1] = '{ch:4'h1, ns:9'd3,   smp:{12'h000, 12'hFFF, 12'h123, 12'hABC}, words:5,
                hdr:32'hA510_0001, pay_first:32'h0ABC_0123, pay_last:32'h0FFF_0000, trl:32'h5A00_0003};
    vecs[2] = '{ch:4'h0, ns:9'd0,   smp:{12'h000, 12'h000, 12'h000, 12'h000}, words:3,
                hdr:32'hA500_0002, pay_first:32'h0, pay_last:32'h0, trl:32'h5A00_0000};
    vecs[3] = '{ch:4'hF, ns:9'd1,   smp:{12'h000, 12'h000, 12'h000, 12'h800}, words:4,
                hdr:32'hA5F0_0003, pay_first:32'h0800_0000, pay_last:32'h0800_0000, trl:32'h5A00_0001};
    vecs[4] = '{ch:4'h7, ns:9'd300, smp:{12'h004, 12'h003, 12'h002, 12'h001}, words:131,
                hdr:32'hA570_0004, pay_first:32'h0001_0002, pay_last:32'h00FF_0100, trl:32'h5A80_0100};

    // Reset state
    repeat (3) tick();
    chk("rst_daq_valid", 32'(daq_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_smp_ready", 32'(smp_ready), 32'h0);
    chk("rst_evt_dropped", 32'(evt_dropped), 32'h0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
    chk("rst_daq_data", daq_data, 32'h0);
    release_reset();

    // Reset asserted in the middle of a payload, with words waiting in the FIFO
    daq_ready = 1'b0;
    frame_smp.delete();
    for (int i = 0; i < 10; i++) frame_smp.push_back(12'(i + 16));
    start_frame(4'h2, 9'd10);
    repeat (4) tick();
    chk("pre_rst_busy", 32'(busy), 32'h1);
    chk("pre_rst_valid", 32'(daq_valid), 32'h1);
    rst_sys_n = 1'b0;
    #1;
    chk("midrst_daq_valid", 32'(daq_valid), 32'h0);
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_smp_ready", 32'(smp_ready), 32'h0);
    repeat (3) tick();
    release_reset();
    daq_ready = 1'b1;

    // Directed vector table
    for (int v = 0; v < 5; v++) begin
      frame_smp.delete();
      for (int i = 0; i < int'(vecs[v].ns); i++)
        frame_smp.push_back((i < 4) ? vecs[v].smp[i] : 12'(i + 1));
      start_frame(vecs[v].ch, vecs[v].ns);
      finish_frame($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_nwords", v), 32'(got_q.size()), 32'(vecs[v].words));
      if (got_q.size() == vecs[v].words) begin
        chk($sformatf("vec%0d_hdr", v), got_q[0], vecs[v].hdr);
        chk($sformatf("vec%0d_ts", v), got_q[1], exp_ts);
        chk($sformatf("vec%0d_trl", v), got_q[vecs[v].words-1], vecs[v].trl);
        if (vecs[v].words > 3) begin
          chk($sformatf("vec%0d_pay_first", v), got_q[2], vecs[v].pay_first);
          chk($sformatf("vec%0d_pay_last", v), got_q[vecs[v].words-2], vecs[v].pay_last);
        end
      end
      if (v == 0) chk("hdr_latency", 32'(first_cyc - start_cyc), 32'd2);
    end

    // Consumer stalled for 40 cycles during a 64-sample event
    frame_smp.delete();
    for (int i = 0; i < 64; i++) frame_smp.push_back(12'($urandom));
    daq_ready = 1'b0;
    start_frame(4'hA, 9'd64);
    hold = '0;
    seen = 1'b0;
    unstable = 0;
    for (int i = 0; i < 39; i++) begin
      tick();
      if (daq_valid) begin
        if (!seen) begin
          hold = daq_data;
          seen = 1'b1;
        end else if (daq_data !== hold) begin
          unstable++;
        end
      end
    end
    chk("stall_taken", 32'(64 - smp_q.size()), 32'd29);
    chk("stall_smp_ready", 32'(smp_ready), 32'h0);
    chk("stall_daq_valid", 32'(daq_valid), 32'h1);
    chk("stall_stable", 32'(unstable), 32'h0);
    chk("stall_hold_hdr", hold, exp_q[0]);
    daq_ready = 1'b1;
    finish_frame("stall");

    // Start request while a payload is being collected
    rst_sys_n = 1'b0;
    repeat (2) tick();
    release_reset();
    frame_smp.delete();
    for (int i = 0; i < 8; i++) frame_smp.push_back(12'($urandom));
    start_frame(4'h5, 9'd8);
    repeat (4) tick();
    chk("drop_in_pay", 32'(busy), 32'h1);
    evt_start = 1'b1;
    evt_channel = 4'h9;
    evt_nsamples = 9'd2;
    exp_drops++;
    tick();
    chk("drop_pulse", 32'(evt_dropped), 32'h1);
    tick();
    chk("drop_pulse_end", 32'(evt_dropped), 32'h0);
    chk("drop_cnt", 32'(drop_cnt), 32'h1);
    finish_frame("drop_frame");
    frame_smp.delete();
    for (int i = 0; i < 2; i++) frame_smp.push_back(12'($urandom));
    start_frame(4'h6, 9'd2);
    finish_frame("after_drop");
    chk("seq_after_drop", (got_q.size() > 0) ? got_q[0] : 32'hFFFF_FFFF, 32'hA560_0001);

    // Randomized frames with sample gaps, consumer backpressure and stray starts
    rand_ready = 1'b1;
    gap_mode = 1'b1;
    for (int e = 0; e < 30; e++) begin
      ns = ($urandom_range(0, 7) == 0) ? 9'($urandom_range(257, 511)) : 9'($urandom_range(0, 40));
      neff = (ns > 9'd256) ? 256 : int'(ns);
      frame_smp.delete();
      for (int i = 0; i < neff; i++) frame_smp.push_back(12'($urandom));
      start_frame(4'($urandom), ns);
      if ($urandom_range(0, 2) == 0) begin
        evt_start = 1'b1;
        evt_channel = 4'($urandom);
        evt_nsamples = 9'($urandom);
        exp_drops++;
        tick();
      end
      finish_frame($sformatf("rand%0d", e));
    end
    chk("rand_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
    chk("rand_drop_pulses", 32'(drop_pulses), 32'(exp_drops));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
